sent_tx_crc_gen: RTL and testbench

- Transmit-side SENT CRC generator. Computes the CRC nibble(s) that the TX frame builder appends to each frame.
- Supports three frame types: fast-channel CRC4 over 6 data nibbles, short-serial CRC4 over 12 bits, and enhanced-serial CRC6 over 24 bits.
- Bit-serial LFSR, one data bit per clock, with a start/busy/valid handshake. It sits between the TX frame assembler and the nibble serializer.

---
 rtl/sent_tx_crc_gen.sv | 178 +++++++++++++++++
 tb/tb_sent_tx_crc_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sent_tx_crc_gen.sv
// Transmit-side SENT CRC generator.
// Bit-serial LFSR producing CRC4 (fast / short-serial) or CRC6 (enhanced serial)
// over a latched message, one bit per clock, with start/busy/valid handshake.
module sent_tx_crc_gen #(
  parameter logic [3:0] SEED4 = 4'b0101,
  parameter logic [5:0] SEED6 = 6'b010101,
  parameter logic [4:0] POLY4 = 5'b11101,
  parameter logic [6:0] POLY6 = 7'b1011001
) (
  input  logic        clk_tx,
  input  logic        reset_tx,
  input  logic        start_crc,
  input  logic [2:0]  enable_crc_gen,
  input  logic [23:0] data_in,
  output logic        busy,
  output logic        crc_valid,
  output logic [5:0]  crc_out,
  output logic        mode_err
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  typedef enum logic [2:0] {
    MODE_FAST  = 3'b001,
    MODE_SHORT = 3'b100,
    MODE_ENH   = 3'b101
  } mode_e;

  // Final counter load is L-1, where L = data bits + CRC width.
  localparam logic [4:0] LAST_FAST  = 5'd27;
  localparam logic [4:0] LAST_SHORT = 5'd15;
  localparam logic [4:0] LAST_ENH   = 5'd29;

  state_e      state_q, state_n;
  logic [23:0] data_q, data_n;
  logic        crc6_q, crc6_n;
  logic [5:0]  lfsr_q, lfsr_n;
  logic [4:0]  count_q, count_n;
  logic        busy_n;
  logic        valid_n;
  logic [5:0]  crc_n;
  logic        err_n;

  // Mode decode results
  logic        mode_ok;
  logic        mode_crc6;
  logic [4:0]  mode_last;
  logic [23:0] mode_data;
  logic [5:0]  mode_seed;

  // LFSR step results
  logic        bit_in;
  logic        fb;
  logic [5:0]  lfsr_step;

  // Decode the requested mode into message alignment, seed, CRC width and length.
  // The message is left-aligned so the serial bit is always data_q[23] and the
  // k trailing zero bits shift in for free once the data has been consumed.
  always_comb begin
    mode_ok   = 1'b0;
    mode_crc6 = 1'b0;
    mode_last = '0;
    mode_data = '0;
    mode_seed = '0;
    case (enable_crc_gen)
      MODE_FAST: begin
        mode_ok   = 1'b1;
        mode_last = LAST_FAST;
        mode_data = data_in;
        mode_seed = {2'b00, SEED4};
      end
      MODE_SHORT: begin
        mode_ok   = 1'b1;
        mode_last = LAST_SHORT;
        mode_data = {data_in[11:0], 12'h000};
        mode_seed = {2'b00, SEED4};
      end
      MODE_ENH: begin
        mode_ok   = 1'b1;
        mode_crc6 = 1'b1;
        mode_last = LAST_ENH;
        mode_data = data_in;
        mode_seed = SEED6;
      end
      default: begin
        mode_ok = 1'b0;
      end
    endcase
  end

  // One LFSR shift: feed the next message bit, fold the polynomial on feedback.
  always_comb begin
    bit_in    = data_q[23];
    fb        = 1'b0;
    lfsr_step = '0;
    if (crc6_q) begin
      fb        = lfsr_q[5];
      lfsr_step = {lfsr_q[4:0], bit_in} ^ (fb ? POLY6[5:0] : 6'b000000);
    end else begin
      fb        = lfsr_q[3];
      lfsr_step = {2'b00, lfsr_q[2:0], bit_in} ^ (fb ? {2'b00, POLY4[3:0]} : 6'b000000);
    end
  end

  // Next-state and registered-output logic for the IDLE/SHIFT controller.
  always_comb begin
    state_n = state_q;
    data_n  = data_q;
    crc6_n  = crc6_q;
    lfsr_n  = lfsr_q;
    count_n = count_q;
    busy_n  = busy;
    valid_n = 1'b0;
    crc_n   = crc_out;
    err_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_crc) begin
          if (mode_ok) begin
            data_n  = mode_data;
            crc6_n  = mode_crc6;
            lfsr_n  = mode_seed;
            count_n = mode_last;
            busy_n  = 1'b1;
            state_n = SHIFT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SHIFT: begin
        data_n  = {data_q[22:0], 1'b0};
        lfsr_n  = lfsr_step;
        count_n = count_q - 5'd1;
        if (count_q == '0) begin
          count_n = '0;
          crc_n   = lfsr_step;
          valid_n = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge clk_tx) begin
    if (reset_tx) begin
      state_q   <= IDLE;
      data_q    <= '0;
      crc6_q    <= 1'b0;
      lfsr_q    <= '0;
      count_q   <= '0;
      busy      <= 1'b0;
      crc_valid <= 1'b0;
      crc_out   <= '0;
      mode_err  <= 1'b0;
    end else begin
      state_q   <= state_n;
      data_q    <= data_n;
      crc6_q    <= crc6_n;
      lfsr_q    <= lfsr_n;
      count_q   <= count_n;
      busy      <= busy_n;
      crc_valid <= valid_n;
      crc_out   <= crc_n;
      mode_err  <= err_n;
    end
  end

endmodule

// File: tb/tb_sent_tx_crc_gen.sv
// Directed and random self-checking bench for sent_tx_crc_gen.
module tb_sent_tx_crc_gen;

  logic        clk_tx;
  logic        reset_tx;
  logic        start_crc;
  logic [2:0]  enable_crc_gen;
  logic [23:0] data_in;
  logic        busy;
  logic        crc_valid;
  logic [5:0]  crc_out;
  logic        mode_err;

  int tests;
  int failed;

  sent_tx_crc_gen #(
    .SEED4(4'b0101),
    .SEED6(6'b010101),
    .POLY4(5'b11101),
    .POLY6(7'b1011001)
  ) dut (
    .clk_tx(clk_tx),
    .reset_tx(reset_tx),
    .start_crc(start_crc),
    .enable_crc_gen(enable_crc_gen),
    .data_in(data_in),
    .busy(busy),
    .crc_valid(crc_valid),
    .crc_out(crc_out),
    .mode_err(mode_err)
  );

  initial clk_tx = 1'b0;
  always #5 clk_tx = ~clk_tx;

  // Global watchdog so the run always ends.
  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues a one-cycle start and returns at the next negedge.
  task automatic launch(input logic [2:0] m, input logic [23:0] d);
    start_crc      = 1'b1;
    enable_crc_gen = m;
    data_in        = d;
    @(negedge clk_tx);
    start_crc      = 1'b0;
  endtask

  // Counts busy samples until completion (bounded) and captures the result.
  task automatic wait_done(output int n, output logic [5:0] res, output logic v);
    n = 0;
    while (busy && n < 64) begin
      n++;
      @(negedge clk_tx);
    end
    res = crc_out;
    v   = crc_valid;
  endtask

  function automatic int frame_len(input logic [2:0] m);
    case (m)
      3'b001:  return 28;
      3'b100:  return 16;
      default: return 30;
    endcase
  endfunction

  // Polynomial long division of {seed, data, crc}; zero means the CRC is consistent.
  function automatic logic [5:0] div_rem(input logic [2:0] m, input logic [23:0] d,
                                         input logic [5:0] c);
    logic [39:0] msg;
    logic [6:0]  poly;
    logic [5:0]  r;
    int          len;
    int          k;
    msg  = '0;
    poly = '0;
    r    = '0;
    len  = 0;
    k    = 4;
    case (m)
      3'b001: begin
        msg = {8'h00, 4'b0101, d, c[3:0]};          len = 32; k = 4; poly = 7'b0011101;
      end
      3'b100: begin
        msg = {20'h00000, 4'b0101, d[11:0], c[3:0]}; len = 20; k = 4; poly = 7'b0011101;
      end
      default: begin
        msg = {4'h0, 6'b010101, d, c};              len = 36; k = 6; poly = 7'b1011001;
      end
    endcase
    for (int i = len - 1; i >= k; i--) begin
      if (msg[i]) begin
        for (int j = 0; j <= k; j++) msg[i-j] = msg[i-j] ^ poly[k-j];
      end
    end
    for (int j = 0; j < k; j++) r[j] = msg[j];
    if (k == 4 && c[5:4] != 2'b00) r = 6'h3F;
    return r;
  endfunction

  initial begin
    int         n;
    logic [5:0] res;
    logic       v;
    int         pulses;
    logic [2:0] m;
    logic [23:0] d;

    tests          = 0;
    failed         = 0;
    reset_tx       = 1'b1;
    start_crc      = 1'b0;
    enable_crc_gen = 3'b000;
    data_in        = '0;

    // Reset and idle
    repeat (2) @(posedge clk_tx);
    @(negedge clk_tx);
    check("rst_busy", busy, 0);
    check("rst_valid", crc_valid, 0);
    check("rst_crc", crc_out, 0);
    check("rst_err", mode_err, 0);
    reset_tx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_tx);
      check("idle_busy", busy, 0);
      check("idle_valid", crc_valid, 0);
      check("idle_err", mode_err, 0);
    end
    check("idle_crc", crc_out, 0);

    // Short-serial, then back-to-back start on the valid cycle
    launch(3'b100, 24'h000000);
    wait_done(n, res, v);
    check("short0_len", n, 16);
    check("short0_valid", v, 1);
    check("short0_crc", res, 6'h09);
    launch(3'b100, 24'h000001);
    check("b2b_busy", busy, 1);
    check("b2b_valid_drop", crc_valid, 0);
    wait_done(n, res, v);
    check("short1_len", n, 16);
    check("short1_valid", v, 1);
    check("short1_crc", res, 6'h04);
    @(negedge clk_tx);
    check("short1_pulse", crc_valid, 0);
    check("short1_hold", crc_out, 6'h04);

    // Fast channel
    launch(3'b001, 24'h000000);
    wait_done(n, res, v);
    check("fast0_len", n, 28);
    check("fast0_valid", v, 1);
    check("fast0_crc", res, 6'h05);
    launch(3'b001, 24'h000001);
    wait_done(n, res, v);
    check("fast1_crc", res, 6'h08);

    // Short-serial ignores data_in[23:12]
    launch(3'b100, 24'hFFF000);
    wait_done(n, res, v);
    check("short_hi_ignored0", res, 6'h09);
    launch(3'b100, 24'hABC001);
    wait_done(n, res, v);
    check("short_hi_ignored1", res, 6'h04);

    // Enhanced CRC6
    launch(3'b101, 24'h000000);
    wait_done(n, res, v);
    check("enh0_len", n, 30);
    check("enh0_valid", v, 1);
    check("enh0_crc", res, 6'h26);
    @(negedge clk_tx);
    check("enh0_pulse", crc_valid, 0);
    check("enh0_idle", busy, 0);

    // Restart and input changes during SHIFT are ignored
    launch(3'b100, 24'h000001);
    repeat (4) @(negedge clk_tx);
    start_crc      = 1'b1;
    enable_crc_gen = 3'b101;
    data_in        = 24'hFFFFFF;
    @(negedge clk_tx);
    start_crc      = 1'b0;
    enable_crc_gen = 3'b010;
    data_in        = 24'h123456;
    check("midrun_busy", busy, 1);
    check("midrun_noerr", mode_err, 0);
    wait_done(n, res, v);
    check("midrun_valid", v, 1);
    check("midrun_crc", res, 6'h04);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_tx);
      if (crc_valid) pulses++;
    end
    check("midrun_single_valid", pulses, 0);

    // Invalid modes
    start_crc      = 1'b1;
    enable_crc_gen = 3'b010;
    @(negedge clk_tx);
    start_crc      = 1'b0;
    check("bad010_err", mode_err, 1);
    check("bad010_busy", busy, 0);
    check("bad010_crc", crc_out, 6'h04);
    @(negedge clk_tx);
    check("bad010_err_pulse", mode_err, 0);
    check("bad010_busy2", busy, 0);
    start_crc      = 1'b1;
    enable_crc_gen = 3'b111;
    @(negedge clk_tx);
    start_crc      = 1'b0;
    check("bad111_err", mode_err, 1);
    check("bad111_valid", crc_valid, 0);
    @(negedge clk_tx);

    // Reset mid-operation
    launch(3'b101, 24'h000000);
    repeat (9) @(negedge clk_tx);
    reset_tx = 1'b1;
    @(negedge clk_tx);
    check("midrst_busy", busy, 0);
    check("midrst_valid", crc_valid, 0);
    check("midrst_crc", crc_out, 0);
    check("midrst_err", mode_err, 0);
    reset_tx = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_tx);
      if (crc_valid || busy) pulses++;
    end
    check("midrst_no_activity", pulses, 0);
    launch(3'b101, 24'h000000);
    wait_done(n, res, v);
    check("fresh_len", n, 30);
    check("fresh_crc", res, 6'h26);

    // Random frames checked by long division
    for (int t = 0; t < 1000; t++) begin
      case ($urandom_range(0, 2))
        0:       m = 3'b001;
        1:       m = 3'b100;
        default: m = 3'b101;
      endcase
      d = 24'($urandom);
      launch(m, d);
      wait_done(n, res, v);
      check("rand_len", n, frame_len(m));
      check("rand_valid", v, 1);
      check("rand_rem", div_rem(m, d, res), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
